// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-granular round-robin arbiter sharing one 64-bit AXI-Stream output
// among NUM_IN sources; caps forwarded packets at MAX_BEATS beats and drains the excess.
module axis_pkt_arbiter #(
    parameter int NUM_IN    = 4,
    parameter int MAX_BEATS = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [64*NUM_IN-1:0]  S_AXIS_TDATA,
    input  logic [8*NUM_IN-1:0]   S_AXIS_TKEEP,
    input  logic [NUM_IN-1:0]     S_AXIS_TLAST,
    input  logic [NUM_IN-1:0]     S_AXIS_TVALID,
    output logic [NUM_IN-1:0]     S_AXIS_TREADY,
    output logic [63:0]           M_AXIS_TDATA,
    output logic [7:0]            M_AXIS_TKEEP,
    output logic                  M_AXIS_TLAST,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic [2:0]            GRANT,
    output logic                  TRIM_PULSE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);
    localparam logic [2:0]  LAST_SRC  = 3'(NUM_IN - 1);

    state_t             state_r, state_s;
    logic [2:0]         grant_r, grant_s;
    logic [2:0]         last_grant_r, last_grant_s;
    logic [2:0]         pick_s;
    logic [15:0]        beat_cnt_r, beat_cnt_s;
    logic               trim_r, trim_s;
    logic [NUM_IN-1:0]  grant_oh_s;
    logic [63:0]        sel_data_s;
    logic [7:0]         sel_keep_s;
    logic               sel_valid_s;
    logic               sel_last_s;
    logic               cap_s;
    logic               hs_s;

    // Select the granted source's lanes with an AND-OR mux so no index ever goes out of range
    always_comb begin
        grant_oh_s  = '0;
        sel_data_s  = 64'd0;
        sel_keep_s  = 8'd0;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            grant_oh_s[i] = (grant_r == 3'(i));
            sel_data_s    = sel_data_s | (S_AXIS_TDATA[64*i +: 64] & {64{grant_oh_s[i]}});
            sel_keep_s    = sel_keep_s | (S_AXIS_TKEEP[8*i +: 8] & {8{grant_oh_s[i]}});
            sel_valid_s   = sel_valid_s | (S_AXIS_TVALID[i] & grant_oh_s[i]);
            sel_last_s    = sel_last_s | (S_AXIS_TLAST[i] & grant_oh_s[i]);
        end
    end

    // Round-robin pick: offsets scanned from farthest to nearest so the nearest valid wins
    always_comb begin
        pick_s = last_grant_r;
        for (int k = NUM_IN; k >= 1; k--) begin
            for (int i = 0; i < NUM_IN; i++) begin
                pick_s = (S_AXIS_TVALID[i] && (((int'(last_grant_r) + k) % NUM_IN) == i))
                         ? 3'(i) : pick_s;
            end
        end
    end

    assign cap_s = (beat_cnt_r == LAST_BEAT);
    assign hs_s  = sel_valid_s & M_AXIS_TREADY;

    // Output steering: data always follows the grant, valid/ready depend on state
    always_comb begin
        M_AXIS_TDATA = sel_data_s;
        M_AXIS_TKEEP = sel_keep_s;
        M_AXIS_TLAST = sel_last_s | cap_s;
        case (state_r)
            ST_PASS: begin
                M_AXIS_TVALID = sel_valid_s;
                S_AXIS_TREADY = grant_oh_s & {NUM_IN{M_AXIS_TREADY}};
            end
            ST_DROP: begin
                M_AXIS_TVALID = 1'b0;
                S_AXIS_TREADY = grant_oh_s;
            end
            default: begin
                M_AXIS_TVALID = 1'b0;
                S_AXIS_TREADY = '0;
            end
        endcase
    end

    // Next-state logic for arbitration, packet pass-through and drain
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        beat_cnt_s   = beat_cnt_r;
        trim_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|S_AXIS_TVALID) begin
                    grant_s    = pick_s;
                    beat_cnt_s = 16'd0;
                    state_s    = ST_PASS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PASS: begin
                if (hs_s) begin
                    if (sel_last_s) begin
                        last_grant_s = grant_r;
                        state_s      = ST_IDLE;
                    end else if (cap_s) begin
                        trim_s  = 1'b1;
                        state_s = ST_DROP;
                    end else begin
                        beat_cnt_s = beat_cnt_r + 16'd1;
                    end
                end else begin
                    state_s = ST_PASS;
                end
            end
            ST_DROP: begin
                if (sel_valid_s && sel_last_s) begin
                    last_grant_s = grant_r;
                    state_s      = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State registers; last_grant resets to the top index so source 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= 3'd0;
            last_grant_r <= LAST_SRC;
            beat_cnt_r   <= 16'd0;
            trim_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            beat_cnt_r   <= beat_cnt_s;
            trim_r       <= trim_s;
        end
    end

    assign GRANT      = grant_r;
    assign TRIM_PULSE = trim_r;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: packet-level source drivers, an integer-level reference
// of the arbitration rules checked every cycle, and directed scenarios with literal expectations.
module tb_axis_pkt_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic [64*N-1:0]  s_tdata;
    logic [8*N-1:0]   s_tkeep;
    logic [N-1:0]     s_tlast;
    logic [N-1:0]     s_tvalid;
    logic [N-1:0]     s_tready;
    logic [63:0]      m_tdata;
    logic [7:0]       m_tkeep;
    logic             m_tlast;
    logic             m_tvalid;
    logic             m_tready;
    logic [2:0]       grant;
    logic             trim;

    int checks = 0;
    int errors = 0;

    // source drivers: packet length, current beat, packets still to send, packet number
    int len[N];
    int beat[N];
    int pkts[N];
    int pktno[N];

    // reference: owner = -1 when no packet is granted
    int owner = -1;
    int fwd   = 0;
    int lastg = N - 1;
    int mg    = 0;
    bit drop  = 1'b0;
    bit mtrim = 1'b0;
    int pkt_order[$];
    int out_beats[N];
    int trims   = 0;
    int dropped = 0;

    axis_pkt_arbiter #(.NUM_IN(N), .MAX_BEATS(MAXB)) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TKEEP  (s_tkeep),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TKEEP  (m_tkeep),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TREADY (m_tready),
        .GRANT         (grant),
        .TRIM_PULSE    (trim)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]         = (pkts[i] > 0);
            s_tlast[i]          = (pkts[i] > 0) && (beat[i] == len[i] - 1);
            s_tdata[64*i +: 64] = {8'(i), 8'(pktno[i]), 16'(beat[i]), 32'hC0DE_0000};
            s_tkeep[8*i +: 8]   = s_tlast[i] ? 8'h0F : 8'hFF;
        end
    endtask

    task automatic send(input int src, input int l, input int n);
        len[src]  = l;
        beat[src] = 0;
        pkts[src] = n;
        drive_srcs();
    endtask

    // Compare DUT against the reference, then advance the reference by one clock
    task automatic model_cycle();
        logic [N-1:0] exp_ready;
        bit           exp_valid;
        bit           exp_last;
        int           pick;
        exp_valid = (owner >= 0) && !drop && s_tvalid[mg];
        exp_last  = s_tlast[mg] || (fwd == MAXB - 1);
        exp_ready = '0;
        if (owner >= 0) exp_ready[mg] = drop ? 1'b1 : m_tready;
        chk("m_tvalid", 64'(m_tvalid), 64'(exp_valid));
        chk("s_tready", 64'(s_tready), 64'(exp_ready));
        chk("grant", 64'(grant), 64'(mg));
        chk("trim_pulse", 64'(trim), 64'(mtrim));
        if (exp_valid) begin
            chk("m_tdata", m_tdata, s_tdata[64*mg +: 64]);
            chk("m_tkeep", 64'(m_tkeep), 64'(s_tkeep[8*mg +: 8]));
            chk("m_tlast", 64'(m_tlast), 64'(exp_last));
        end
        if (exp_valid && m_tready && !rst) begin
            chk("beat_order", 64'(m_tdata[47:32]), 64'(fwd));
            out_beats[mg]++;
            if (exp_last) pkt_order.push_back(mg);
        end
        if (rst) begin
            owner = -1; fwd = 0; lastg = N - 1; mg = 0; drop = 1'b0; mtrim = 1'b0;
        end else begin
            mtrim = 1'b0;
            if (owner < 0) begin
                pick = -1;
                for (int k = 1; k <= N; k++)
                    if (pick < 0 && s_tvalid[(lastg + k) % N]) pick = (lastg + k) % N;
                if (pick >= 0) begin
                    owner = pick; mg = pick; fwd = 0; drop = 1'b0;
                end
            end else if (!drop) begin
                if (s_tvalid[mg] && m_tready) begin
                    if (s_tlast[mg]) begin
                        lastg = mg; owner = -1;
                    end else if (fwd == MAXB - 1) begin
                        drop = 1'b1; mtrim = 1'b1; trims++;
                    end else begin
                        fwd++;
                    end
                end
            end else if (s_tvalid[mg]) begin
                dropped++;
                if (s_tlast[mg]) begin
                    lastg = mg; owner = -1; drop = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = s_tvalid & s_tready;
        model_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if (beat[i] == len[i] - 1) begin
                    beat[i] = 0; pkts[i]--; pktno[i]++;
                end else begin
                    beat[i]++;
                end
            end
        end
        drive_srcs();
    endtask

    function automatic bit busy();
        bit b = (owner >= 0);
        for (int i = 0; i < N; i++) if (pkts[i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while (n < budget && busy()) begin
            step();
            n++;
        end
        chk(name, 64'(busy()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int b_beats;
        int b_trims;
        int b_drop;
        int exp2[5];
        exp2 = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        m_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            len[i] = 1; beat[i] = 0; pkts[i] = 0; pktno[i] = 0; out_beats[i] = 0;
        end
        drive_srcs();
        step();
        step();
        rst = 1'b0;

        // T1: single 3-beat packet from source 0, cycle-exact
        send(0, 3, 1);
        step(); #2;
        chk("t1_grant_c1", 64'(grant), 64'd0);
        chk("t1_valid_c1", 64'(m_tvalid), 64'd1);
        chk("t1_beat0_data", m_tdata, 64'h0000_0000_C0DE_0000);
        step(); step(); #2;
        chk("t1_tlast_c3", 64'(m_tlast), 64'd1);
        chk("t1_data_c3", m_tdata, 64'h0000_0002_C0DE_0000);
        step(); #2;
        chk("t1_idle_c4", 64'(m_tvalid), 64'd0);
        chk("t1_trim_c4", 64'(trim), 64'd0);
        run_until_idle("t1_timeout", 20);

        // T2: all sources busy with 2-beat packets, rotation order 0,1,2,3,0
        do_reset();
        base = pkt_order.size();
        send(0, 2, 2); send(1, 2, 1); send(2, 2, 1); send(3, 2, 1);
        run_until_idle("t2_timeout", 60);
        chk("t2_pkt_count", 64'(pkt_order.size() - base), 64'd5);
        for (int k = 0; k < 5; k++)
            if (base + k < pkt_order.size())
                chk("t2_grant_order", 64'(pkt_order[base + k]), 64'(exp2[k]));

        // T3: 10-beat packet from source 2 truncated at 7 beats
        do_reset();
        b_beats = out_beats[2]; b_trims = trims; b_drop = dropped;
        send(2, 10, 1);
        for (int k = 0; k < 8; k++) step();
        #2;
        chk("t3_trim_high", 64'(trim), 64'd1);
        chk("t3_drop_valid", 64'(m_tvalid), 64'd0);
        chk("t3_drop_ready", 64'(s_tready), 64'b0100);
        step(); #2;
        chk("t3_trim_low", 64'(trim), 64'd0);
        run_until_idle("t3_timeout", 30);
        chk("t3_fwd_beats", 64'(out_beats[2] - b_beats), 64'd7);
        chk("t3_trims", 64'(trims - b_trims), 64'd1);
        chk("t3_dropped", 64'(dropped - b_drop), 64'd3);

        // T4: exactly MAX_BEATS beats with natural TLAST, no trim
        b_beats = out_beats[1]; b_trims = trims; b_drop = dropped;
        send(1, 7, 1);
        run_until_idle("t4_timeout", 30);
        chk("t4_fwd_beats", 64'(out_beats[1] - b_beats), 64'd7);
        chk("t4_trims", 64'(trims - b_trims), 64'd0);
        chk("t4_dropped", 64'(dropped - b_drop), 64'd0);

        // T5: downstream ready toggling during a 4-beat packet
        b_beats = out_beats[3];
        send(3, 4, 1);
        for (int k = 0; k < 12; k++) begin
            m_tready = (k % 2 == 0);
            step();
        end
        m_tready = 1'b1;
        run_until_idle("t5_timeout", 30);
        chk("t5_fwd_beats", 64'(out_beats[3] - b_beats), 64'd4);

        // T6: reset in the middle of a source-3 packet, then 0 and 3 compete
        do_reset();
        send(3, 6, 1);
        step(); step(); step(); #2;
        chk("t6_pre_grant", 64'(grant), 64'd3);
        rst = 1'b1;
        pkts[3] = 0;
        drive_srcs();
        step();
        rst = 1'b0;
        #2;
        chk("t6_rst_valid", 64'(m_tvalid), 64'd0);
        chk("t6_rst_ready", 64'(s_tready), 64'd0);
        chk("t6_rst_grant", 64'(grant), 64'd0);
        chk("t6_rst_trim", 64'(trim), 64'd0);
        base = pkt_order.size();
        send(0, 2, 1); send(3, 2, 1);
        run_until_idle("t6_timeout", 30);
        chk("t6_pkt_count", 64'(pkt_order.size() - base), 64'd2);
        if (pkt_order.size() >= base + 2) begin
            chk("t6_first", 64'(pkt_order[base]), 64'd0);
            chk("t6_second", 64'(pkt_order[base + 1]), 64'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-granular round-robin arbiter that shares one 64-bit AXI-Stream output among NUM_IN AXI-Stream sources. It holds the grant for a whole packet and caps each forwarded packet at MAX_BEATS beats. On a cap it forces TLAST on the last allowed beat, then silently drains the rest of the source packet. It sits between the per-source packet generators and the single downstream consumer (MAC/DMA) in the 64-bit stream datapath.

## Interface
Parameters:
- NUM_IN, 4: number of source streams, 2..8.
- MAX_BEATS, 7: maximum forwarded beats per packet, 1..65535.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- S_AXIS_TDATA  in  64*NUM_IN  source data; source i at bits [64*i+63:64*i].
- S_AXIS_TKEEP  in  8*NUM_IN  source byte keeps, same packing.
- S_AXIS_TLAST  in  NUM_IN  source end-of-packet.
- S_AXIS_TVALID  in  NUM_IN  source valid.
- S_AXIS_TREADY  out  NUM_IN  source ready.
- M_AXIS_TDATA  out  64  output data.
- M_AXIS_TKEEP  out  8  output byte keep.
- M_AXIS_TLAST  out  1  output end-of-packet (source TLAST or forced).
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TREADY  in  1  downstream ready.
- GRANT  out  3  index of the current/last granted source.
- TRIM_PULSE  out  1  one-cycle pulse when a packet is truncated.

## Operation
- State machine with three states: IDLE, PASS, DROP. Registers: state, GRANT (3 b), last_grant (3 b), beat_cnt (16 b).
- IDLE:
  - M_AXIS_TVALID=0; all S_AXIS_TREADY=0.
  - If any S_AXIS_TVALID is set, select the first valid index scanning last_grant+1, last_grant+2, … modulo NUM_IN.
  - Register the selection into GRANT, clear beat_cnt, go to PASS.
- PASS, g=GRANT:
  - M_AXIS_TDATA, M_AXIS_TKEEP and M_AXIS_TVALID are driven combinationally from source g.
  - S_AXIS_TREADY[g]=M_AXIS_TREADY; all other readies are 0.
  - M_AXIS_TLAST = S_AXIS_TLAST[g] OR (beat_cnt == MAX_BEATS-1).
  - On handshake (S_AXIS_TVALID[g] AND M_AXIS_TREADY):
    - If S_AXIS_TLAST[g]: go to IDLE, last_grant<=g. This applies even when beat_cnt==MAX_BEATS-1; no trim occurs.
    - Else if beat_cnt==MAX_BEATS-1: go to DROP, pulse TRIM_PULSE next cycle.
    - Else: beat_cnt<=beat_cnt+1.
  - Without a handshake, all registers hold.
- DROP:
  - M_AXIS_TVALID=0; S_AXIS_TREADY[g]=1 regardless of M_AXIS_TREADY; all others 0.
  - Every S_AXIS_TVALID[g] beat is discarded.
  - On S_AXIS_TVALID[g] AND S_AXIS_TLAST[g]: go to IDLE, last_grant<=g.
- When M_AXIS_TVALID=0, M_AXIS_TDATA, M_AXIS_TKEEP and M_AXIS_TLAST are don't-care, but driven from source g. No X-propagation is permitted.
- beat_cnt never exceeds MAX_BEATS-1; no wrap-around.
- GRANT holds its value in IDLE.

## Timing
- Reset values: state=IDLE, GRANT=0, last_grant=NUM_IN-1 (source 0 has first priority), beat_cnt=0, TRIM_PULSE=0, M_AXIS_TVALID=0, S_AXIS_TREADY=0.
- Reset mid-packet aborts the packet without issuing TLAST. Sources must restart their packets.
- Arbitration latency: one cycle.
  - A request seen in IDLE at cycle N gives the first possible output beat at cycle N+1.
  - Each packet boundary costs exactly one idle cycle (IDLE is always visited).
- Data path: zero-latency combinational pass-through in PASS. TDATA/TKEEP are never modified.
- TRIM_PULSE is registered: asserted the cycle after the capping handshake, for exactly 1 cycle.
- Sources deasserting TVALID mid-packet keep the grant; there is no timeout.
- A request arriving in the same cycle as a PASS→IDLE transition is arbitrated in the following IDLE cycle. The index just served has lowest priority.

## Test plan
- Single source 0, 3-beat packet, M_AXIS_TREADY=1:
  - GRANT=0 at cycle 1.
  - Output beats on cycles 1–3, TLAST on beat 3.
  - IDLE on cycle 4; TRIM_PULSE stays 0.
- Sources 0–3 all continuously valid with 2-beat packets:
  - Grant order 0,1,2,3,0.
  - Output shows 2 beats + 1 idle cycle per packet.
  - No interleaving of beats between sources.
- Source 2 sends a 10-beat packet with MAX_BEATS=7:
  - Output carries beats 0–6, TLAST forced on beat 6.
  - Beats 7–9 are consumed with M_AXIS_TVALID=0.
  - TRIM_PULSE is high for one cycle after beat 6.
- Source 1 sends exactly 7 beats, TLAST on beat 7:
  - Forwarded intact; state goes directly PASS→IDLE.
  - No DROP state; TRIM_PULSE=0.
- M_AXIS_TREADY toggles 1,0,1,0 during a 4-beat packet:
  - Output beats hold stable while TREADY=0.
  - beat_cnt advances only on handshakes; all 4 beats arrive in order.
- Assert rst mid-packet at beat 2 of source 3, then source 0 and source 3 both request:
  - All outputs reach their reset values the next cycle.
  - Source 0 is granted first.
